// File: rtl/pgmflash_pkg.sv
// Shared definitions for the pgmflash ROM data path.
//
// Contents:
//   ROM_AW        ROM byte address width (512 KiB part).
//   CMD_RD/CMD_WR command type encoding used between the port logic and the
//                 ROM cycle sequencer.
//   cyc_state_e   state encoding of the ROM cycle FSM (also exported for debug).
//   PORT_*        ZX IO port addresses decoded upstream (shared with the bench).
//   next_phase()  0->1->2->0 step of the three-phase address loader.
package pgmflash_pkg;

    localparam int ROM_AW = 19;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam logic [7:0] PORT_CTRL = 8'h33;
    localparam logic [7:0] PORT_AUX  = 8'h3B;
    localparam logic [7:0] PORT_ADDR = 8'hB3;
    localparam logic [7:0] PORT_DATA = 8'hBB;

    typedef enum logic [2:0] {
        CYC_IDLE  = 3'd0,
        CYC_REQ   = 3'd1,
        CYC_SETUP = 3'd2,
        CYC_STB   = 3'd3,
        CYC_HOLD  = 3'd4
    } cyc_state_e;

    function automatic logic [1:0] next_phase(input logic [1:0] phase);
        return (phase == 2'd2) ? 2'd0 : phase + 2'd1;
    endfunction

endpackage

// File: rtl/rom_cyc_seq.sv
// Single-byte ROM bus cycle sequencer.
//
// Runs one READ or WRITE on the shared ROM bus per accepted command:
// IDLE -> REQ (wait bus_gnt) -> SETUP (SETUP_CYC) -> STB (STB_CYC) -> HOLD (1).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (see below)
//   cmd_type          CMD_RD / CMD_WR
//   cmd_addr          ROM byte address of the command
//   cmd_data          write data (ignored for reads)
//   rd_data/rd_valid  read byte; rd_valid pulses on the last strobe cycle
//   bus_req/bus_gnt   ROM bus request to the arbiter / grant
//   mem_*, romcs_n,
//   memoe_n, memwe_n  ROM pin drive (all registered)
//   state_dbg         current FSM state
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready are
// both high. cmd_ready is high in IDLE and in HOLD; accepting in HOLD chains
// straight back into REQ with bus_req still asserted. cmd_* must be stable
// while cmd_valid is high; rd_valid is a single-cycle pulse with no backpressure.
module rom_cyc_seq
    import pgmflash_pkg::*;
#(
    parameter int AW        = ROM_AW,
    parameter int STB_CYC   = 3,
    parameter int SETUP_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic          cmd_type,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_data,
    output logic          cmd_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          bus_gnt,
    output logic          bus_req,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_dout,
    output logic          mem_doe,
    input  logic [7:0]    mem_din,
    output logic          romcs_n,
    output logic          memoe_n,
    output logic          memwe_n,
    output cyc_state_e    state_dbg
);

    localparam int CW = 8;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STB_LAST   = CW'(STB_CYC - 1);

    cyc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          type_q, type_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          bus_req_q, bus_req_d;
    logic          mem_doe_q, mem_doe_d;
    logic          romcs_n_q, romcs_n_d;
    logic          memoe_n_q, memoe_n_d;
    logic          memwe_n_q, memwe_n_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bus_req_d = bus_req_q;
        mem_doe_d = mem_doe_q;
        romcs_n_d = romcs_n_q;
        memoe_n_d = memoe_n_q;
        memwe_n_d = memwe_n_q;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;

        case (state_q)
            CYC_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    type_d    = cmd_type;
                    addr_d    = cmd_addr;
                    data_d    = cmd_data;
                    bus_req_d = 1'b1;
                    state_d   = CYC_REQ;
                end
            end
            CYC_REQ: begin
                if (bus_gnt) begin
                    romcs_n_d = 1'b0;
                    mem_doe_d = (type_q == CMD_WR);
                    cnt_d     = '0;
                    state_d   = CYC_SETUP;
                end
            end
            CYC_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d     = '0;
                    memoe_n_d = (type_q != CMD_RD);
                    memwe_n_d = (type_q != CMD_WR);
                    state_d   = CYC_STB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CYC_STB: begin
                if (cnt_q == STB_LAST) begin
                    // mem_din is sampled on the edge that ends the strobe.
                    rd_valid  = (type_q == CMD_RD);
                    memoe_n_d = 1'b1;
                    memwe_n_d = 1'b1;
                    state_d   = CYC_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CYC_HOLD: begin
                // Strobe is already high; CE and data drive end on this edge.
                cmd_ready = 1'b1;
                romcs_n_d = 1'b1;
                mem_doe_d = 1'b0;
                if (cmd_valid) begin
                    type_d  = cmd_type;
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    state_d = CYC_REQ;
                end else begin
                    bus_req_d = 1'b0;
                    state_d   = CYC_IDLE;
                end
            end
            default: begin
                state_d = CYC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CYC_IDLE;
            cnt_q     <= '0;
            type_q    <= CMD_RD;
            addr_q    <= '0;
            data_q    <= '0;
            bus_req_q <= 1'b0;
            mem_doe_q <= 1'b0;
            romcs_n_q <= 1'b1;
            memoe_n_q <= 1'b1;
            memwe_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bus_req_q <= bus_req_d;
            mem_doe_q <= mem_doe_d;
            romcs_n_q <= romcs_n_d;
            memoe_n_q <= memoe_n_d;
            memwe_n_q <= memwe_n_d;
        end
    end

    // Address and data only change on command acceptance (IDLE or HOLD exit),
    // so they are stable for the whole time romcs_n is low.
    assign mem_a     = addr_q;
    assign mem_dout  = data_q;
    assign mem_doe   = mem_doe_q;
    assign bus_req   = bus_req_q;
    assign romcs_n   = romcs_n_q;
    assign memoe_n   = memoe_n_q;
    assign memwe_n   = memwe_n_q;
    assign rd_data   = mem_din;
    assign state_dbg = state_q;

endmodule

// File: rtl/pgmflash_rom_port.sv
// ZX port 0xB3/0xBB data path of the pgmflash design.
//
// Keeps the three-phase ROM address loader (0xB3), the auto-incrementing
// ROM address, a single-entry pending command slot, the read latch returned
// on 0xBB reads (one-deep read pipeline) and the sticky overrun flag. ROM
// bus cycles themselves are run by rom_cyc_seq.
//
// Ports:
//   clk, rst        clk_fpga, synchronous active-high reset
//   addr_wr_stb     ZX write to 0xB3 (1-cycle pulse)
//   data_wr_stb     ZX write to 0xBB (1-cycle pulse)
//   data_rd_stb     start of ZX read of 0xBB (1-cycle pulse)
//   init_stb        write of 0x33 with bit7 set (1-cycle pulse)
//   zx_din          ZX write data, valid with the strobes
//   zx_dout         byte returned for a 0xBB read (read latch)
//   bus_req/bus_gnt ROM bus request / synchronised grant
//   mem_a, mem_dout,
//   mem_doe, mem_din,
//   romcs_n, memoe_n,
//   memwe_n         shared ROM bus
//   busy            cycle running or command pending
//   overrun         sticky: a command was dropped (cleared by init_stb/rst)
//
// AW must lie in 17..24: the third loader phase fills rom_addr[AW-1:16].
module pgmflash_rom_port
    import pgmflash_pkg::*;
#(
    parameter int AW        = ROM_AW,
    parameter int STB_CYC   = 3,
    parameter int SETUP_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          addr_wr_stb,
    input  logic          data_wr_stb,
    input  logic          data_rd_stb,
    input  logic          init_stb,
    input  logic [7:0]    zx_din,
    output logic [7:0]    zx_dout,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_dout,
    output logic          mem_doe,
    input  logic [7:0]    mem_din,
    output logic          romcs_n,
    output logic          memoe_n,
    output logic          memwe_n,
    output logic          busy,
    output logic          overrun
);

    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    rd_latch_q, rd_latch_d;
    logic          overrun_q, overrun_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_type_q, pend_type_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]    pend_data_q, pend_data_d;

    logic          new_cmd;
    logic          new_type;
    logic          cmd_valid;
    logic          cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_data;
    logic          cmd_ready;
    logic [7:0]    rd_data;
    logic          rd_valid;
    cyc_state_e    seq_state;

    always_comb begin
        rom_addr_d   = rom_addr_q;
        phase_d      = phase_q;
        rd_latch_d   = rd_latch_q;
        overrun_d    = overrun_q;
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;

        new_cmd  = data_wr_stb | data_rd_stb;
        new_type = data_wr_stb ? CMD_WR : CMD_RD;

        // The pending slot is older than any new strobe, so it always goes
        // first; a new command only bypasses the slot when the slot is empty.
        cmd_valid = pend_valid_q | new_cmd;
        if (pend_valid_q) begin
            cmd_type = pend_type_q;
            cmd_addr = pend_addr_q;
            cmd_data = pend_data_q;
        end else begin
            cmd_type = new_type;
            cmd_addr = rom_addr_q;
            cmd_data = zx_din;
        end

        if (pend_valid_q && cmd_ready) begin
            pend_valid_d = 1'b0;
        end

        if (new_cmd) begin
            // The address advances even when the command is dropped, so the
            // host's view of the address never depends on engine timing.
            rom_addr_d = rom_addr_q + AW'(1);
            phase_d    = 2'd0;
            if (pend_valid_q && !cmd_ready) begin
                overrun_d = 1'b1;
            end else if (pend_valid_q || !cmd_ready) begin
                pend_valid_d = 1'b1;
                pend_type_d  = new_type;
                pend_addr_d  = rom_addr_q;
                pend_data_d  = zx_din;
            end
        end else if (addr_wr_stb) begin
            case (phase_q)
                2'd0:    rom_addr_d[7:0]     = zx_din;
                2'd1:    rom_addr_d[15:8]    = zx_din;
                default: rom_addr_d[AW-1:16] = zx_din[AW-17:0];
            endcase
            phase_d = next_phase(phase_q);
        end

        if (init_stb) begin
            phase_d   = 2'd0;
            overrun_d = 1'b0;
        end

        if (rd_valid) begin
            rd_latch_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q   <= '0;
            phase_q      <= 2'd0;
            rd_latch_q   <= 8'hFF;
            overrun_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= CMD_RD;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            phase_q      <= phase_d;
            rd_latch_q   <= rd_latch_d;
            overrun_q    <= overrun_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    rom_cyc_seq #(
        .AW        (AW),
        .STB_CYC   (STB_CYC),
        .SETUP_CYC (SETUP_CYC)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .bus_gnt   (bus_gnt),
        .bus_req   (bus_req),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_doe   (mem_doe),
        .mem_din   (mem_din),
        .romcs_n   (romcs_n),
        .memoe_n   (memoe_n),
        .memwe_n   (memwe_n),
        .state_dbg (seq_state)
    );

    assign zx_dout = rd_latch_q;
    assign overrun = overrun_q;
    assign busy    = (seq_state != CYC_IDLE) | pend_valid_q;

endmodule

// File: tb/tb_pgmflash_rom_port.sv
`timescale 1ns/1ps
module tb_pgmflash_rom_port;
    import pgmflash_pkg::*;

    localparam int AW        = 19;
    localparam int STB_CYC   = 3;
    localparam int SETUP_CYC = 1;
    localparam int AMASK     = (1 << AW) - 1;
    localparam int OW        = 1 + AW + 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          addr_wr_stb = 1'b0;
    logic          data_wr_stb = 1'b0;
    logic          data_rd_stb = 1'b0;
    logic          init_stb = 1'b0;
    logic [7:0]    zx_din = 8'h00;
    logic [7:0]    zx_dout;
    logic          bus_req;
    logic          bus_gnt = 1'b0;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_dout;
    logic          mem_doe;
    logic [7:0]    mem_din;
    logic          romcs_n;
    logic          memoe_n;
    logic          memwe_n;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    pgmflash_rom_port #(.AW(AW), .STB_CYC(STB_CYC), .SETUP_CYC(SETUP_CYC)) dut (
        .clk(clk), .rst(rst), .addr_wr_stb(addr_wr_stb), .data_wr_stb(data_wr_stb),
        .data_rd_stb(data_rd_stb), .init_stb(init_stb), .zx_din(zx_din), .zx_dout(zx_dout),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_doe(mem_doe), .mem_din(mem_din), .romcs_n(romcs_n), .memoe_n(memoe_n),
        .memwe_n(memwe_n), .busy(busy), .overrun(overrun)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- ROM device + reference memory ----------------
    logic [7:0] dev_mem [int];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] dflt(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dev_rd(input int a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory drives noise unless it is selected and output-enabled.
    always @(posedge clk) begin
        #1;
        if (!romcs_n && !memwe_n) dev_mem[int'(mem_a)] = mem_dout;
        mem_din = (!romcs_n && !memoe_n) ? dev_rd(int'(mem_a)) : 8'($urandom);
    end

    // ---------------- bus monitor + scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs_hist[$];
    int            cs_cycles = 0;
    int            req_gap   = 0;
    bit            mon_active = 0;
    int            mon_setup, mon_stb, mon_hold;
    bit            mon_wr, mon_bad, mon_doe;
    logic [AW-1:0] mon_a;
    logic [7:0]    mon_data;
    logic [OW-1:0] mon_obs;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
        end else begin
            if (busy && !bus_req) req_gap++;
            if (!romcs_n) begin
                cs_cycles++;
                if (!mon_active) begin
                    mon_active = 1; mon_setup = 0; mon_stb = 0; mon_hold = 0;
                    mon_wr = 0; mon_bad = 0; mon_a = mem_a; mon_doe = mem_doe; mon_data = 8'h00;
                end
                if (mem_a !== mon_a || mem_doe !== mon_doe) mon_bad = 1;
                if (!memoe_n || !memwe_n) begin
                    if ((!memoe_n && !memwe_n) || mon_hold > 0) mon_bad = 1;
                    mon_stb++;
                    mon_wr   = !memwe_n;
                    mon_data = !memwe_n ? mem_dout : mem_din;
                end else if (mon_stb == 0) begin
                    mon_setup++;
                end else begin
                    mon_hold++;
                end
            end else if (mon_active) begin
                mon_active = 0;
                check("stb_width", mon_stb, STB_CYC);
                check("setup_len", mon_setup, SETUP_CYC);
                check("hold_len", mon_hold, 1);
                check("pins_stable", {31'd0, mon_bad}, 0);
                check("doe_match", {31'd0, mon_doe}, {31'd0, mon_wr});
                mon_obs = {mon_wr, mon_a, mon_data};
                obs_hist.push_back(mon_obs);
                if (exp_q.size() == 0) check("extra_rom_cycle", 32'(mon_obs), 32'hFFFF_FFFF);
                else check("rom_cycle", 32'(mon_obs), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [AW-1:0] obs_addr(input int back);
        logic [OW-1:0] o;
        o = obs_hist[obs_hist.size() - 1 - back];
        return o[AW+7:8];
    endfunction

    // ---------------- reference model state ----------------
    int         m_addr  = 0;
    int         m_phase = 0;
    logic [7:0] m_latch = 8'hFF;
    logic       m_ovr   = 1'b0;

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b3_write(input logic [7:0] d);
        addr_wr_stb = 1'b1; zx_din = d;
        step();
        addr_wr_stb = 1'b0;
        m_addr  = ((m_addr & ~(255 << (8 * m_phase))) | (int'(d) << (8 * m_phase))) & AMASK;
        m_phase = (m_phase + 1) % 3;
    endtask

    task automatic load_addr(input int a);
        b3_write(8'(a)); b3_write(8'(a >> 8)); b3_write(8'(a >> 16));
    endtask

    task automatic init_pulse();
        init_stb = 1'b1;
        step();
        init_stb = 1'b0;
        m_phase = 0; m_ovr = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin step(); t++; end
        check("idle_reached", {31'd0, busy}, 0);
        step(); step();
        check("idle_bus_req", {31'd0, bus_req}, 0);
        check("idle_romcs_n", {31'd0, romcs_n}, 1);
    endtask

    // Back-to-back data strobes with the engine idle: the first starts, the
    // second waits in the pending slot, anything further is dropped.
    task automatic burst(input int n, input logic [2:0] wr_mask, input logic [23:0] dbytes,
                         input bit gnt_early, input int gnt_delay);
        logic [7:0] new_latch;
        int         gap0;
        new_latch = m_latch;
        gap0 = req_gap;
        bus_gnt = gnt_early;
        for (int k = 0; k < n; k++) begin
            logic       w;
            logic [7:0] d;
            w = wr_mask[k];
            d = dbytes[8*k +: 8];
            data_wr_stb = w; data_rd_stb = !w; zx_din = d;
            if (!w) check("zx_dout_at_read", 32'(zx_dout), 32'(m_latch));
            if (k < 2) begin
                if (w) begin
                    ref_mem[m_addr] = d;
                    exp_q.push_back({1'b1, AW'(m_addr), d});
                end else begin
                    new_latch = ref_rd(m_addr);
                    exp_q.push_back({1'b0, AW'(m_addr), new_latch});
                end
            end else begin
                m_ovr = 1'b1;
            end
            m_addr = (m_addr + 1) & AMASK;
            m_phase = 0;
            step();
        end
        data_wr_stb = 1'b0; data_rd_stb = 1'b0;
        repeat (gnt_delay) step();
        bus_gnt = 1'b1;
        wait_idle();
        bus_gnt = 1'b0;
        m_latch = new_latch;
        check("req_held", req_gap, gap0);
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check("zx_dout_after", 32'(zx_dout), 32'(m_latch));
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        int c0;
        repeat (3) step();
        rst = 1'b0;

        // reset state
        check("rst_zx_dout", 32'(zx_dout), 32'hFF);
        check("rst_bus_req", {31'd0, bus_req}, 0);
        check("rst_romcs_n", {31'd0, romcs_n}, 1);
        check("rst_memoe_n", {31'd0, memoe_n}, 1);
        check("rst_memwe_n", {31'd0, memwe_n}, 1);
        check("rst_mem_doe", {31'd0, mem_doe}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);

        // read pipeline
        dev_mem[32'h100] = 8'h11; dev_mem[32'h101] = 8'h22; dev_mem[32'h102] = 8'h33;
        ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22; ref_mem[32'h102] = 8'h33;
        load_addr(32'h00100);
        check("pipe_rd0", 32'(zx_dout), 32'hFF);
        burst(1, 3'b000, 24'h0, 1'b1, 0);
        check("pipe_rd1", 32'(zx_dout), 32'h11);
        burst(1, 3'b000, 24'h0, 1'b0, 2);
        check("pipe_rd2", 32'(zx_dout), 32'h22);
        burst(1, 3'b000, 24'h0, 1'b0, 0);
        check("pipe_a0", 32'(obs_addr(2)), 32'h100);
        check("pipe_a1", 32'(obs_addr(1)), 32'h101);
        check("pipe_a2", 32'(obs_addr(0)), 32'h102);

        // address load
        b3_write(8'h34); b3_write(8'h12); b3_write(8'h05);
        burst(1, 3'b001, 24'h0000A5, 1'b0, 3);
        check("load_write", 32'(obs_hist[obs_hist.size()-1]), 32'({1'b1, 19'h51234, 8'hA5}));
        burst(1, 3'b000, 24'h0, 1'b1, 0);
        check("load_incr", 32'(obs_addr(0)), 32'h51235);

        // wrap with delayed grant and two queued writes
        load_addr(32'h7FFFF);
        burst(2, 3'b011, 24'h00C3B2, 1'b0, 10);
        check("wrap_a0", 32'(obs_addr(1)), 32'h7FFFF);
        check("wrap_a1", 32'(obs_addr(0)), 32'h00000);

        // overrun with grant held low
        load_addr(32'h12000);
        n0 = obs_hist.size();
        burst(3, 3'b111, 24'h030201, 1'b0, 4);
        check("ovr_flag", {31'd0, overrun}, 1);
        check("ovr_cycles", obs_hist.size() - n0, 2);
        burst(1, 3'b000, 24'h0, 1'b1, 0);
        check("ovr_addr_adv", 32'(obs_addr(0)), 32'h12003);

        // phase reset via init
        b3_write(8'hAA);
        init_pulse();
        check("init_clr_ovr", {31'd0, overrun}, 0);
        b3_write(8'h01); b3_write(8'h02); b3_write(8'h03);
        burst(1, 3'b000, 24'h0, 1'b0, 1);
        check("phase_addr", 32'(obs_addr(0)), 32'h30201);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            int nb;
            nb = $urandom_range(0, 3);
            for (int j = 0; j < nb; j++) b3_write(8'($urandom));
            if ($urandom_range(0, 7) == 0) init_pulse();
            burst($urandom_range(1, 3), 3'($urandom), 24'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end

        // reset in the middle of a write strobe, with a second write pending
        bus_gnt = 1'b1;
        ref_mem[m_addr] = 8'h5C;
        data_wr_stb = 1'b1; zx_din = 8'h5C;
        step();
        zx_din = 8'hC5;
        step();
        data_wr_stb = 1'b0;
        for (int t = 0; t < 50 && memwe_n; t++) step();
        check("rst_mid_we_seen", {31'd0, memwe_n}, 0);
        rst = 1'b1;
        step();
        check("rstm_memwe_n", {31'd0, memwe_n}, 1);
        check("rstm_memoe_n", {31'd0, memoe_n}, 1);
        check("rstm_romcs_n", {31'd0, romcs_n}, 1);
        check("rstm_bus_req", {31'd0, bus_req}, 0);
        check("rstm_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        exp_q.delete();
        m_addr = 0; m_phase = 0; m_latch = 8'hFF; m_ovr = 1'b0;
        c0 = cs_cycles;
        repeat (20) step();
        check("rstm_no_cycle", cs_cycles, c0);
        burst(1, 3'b000, 24'h0, 1'b1, 0);
        check("rstm_addr0", 32'(obs_addr(0)), 32'h0);

        check("final_exp_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (got=timeout expected=finish)");
        $fatal(1, "watchdog");
    end

endmodule
